// File: rtl/decoder_pkg.sv
// Shared 3-to-8 decode constants and the one-hot helper.
// Reused by any block that turns a 3-bit select into strobes.
package decoder_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 2 ** IN_W;

  function automatic logic [OUT_W-1:0] onehot3(
    input logic [IN_W-1:0] sel
  );
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/decoder3to8_comb.sv
// Combinational 3-to-8 decode with selectable output polarity.
// Shared by the registered path and the same-cycle y_comb output.
module decoder3to8_comb
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y_comb
);

  assign y_comb = onehot3(a) ^ {OUT_W{ACTIVE_LOW}};

endmodule

// File: rtl/decoder3to8_b.sv
// Registered 3-to-8 one-hot decoder with enable and output-valid.
// y_comb is the ungated same-cycle decode of a.
module decoder3to8_b
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y_comb,
  output logic [OUT_W-1:0] y,
  output logic             y_valid
);

  localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW}};

  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;
  logic             y_valid_d;
  logic             y_valid_q;

  decoder3to8_comb #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_comb (
    .a     (a),
    .y_comb(y_comb)
  );

  always_comb begin
    y_d       = IDLE;
    y_valid_d = 1'b0;
    if (en) begin
      y_d       = y_comb;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= IDLE;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_decoder3to8_b.sv
// Self-checking bench for decoder3to8_b, both output polarities.
// Expected results are queued at drive time and popped after the edge.
module tb_decoder3to8_b;

  typedef struct packed {
    logic       v;
    logic [7:0] y;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] a;
  logic [7:0] yc_hi, y_hi, yc_lo, y_lo;
  logic       v_hi, v_lo;

  logic [7:0] tbl [8];
  exp_t       sb [$];
  int         checks;
  int         errors;

  decoder3to8_b #(.ACTIVE_LOW(1'b0)) u_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .y_comb (yc_hi),
    .y      (y_hi),
    .y_valid(v_hi)
  );

  decoder3to8_b #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .y_comb (yc_lo),
    .y      (y_lo),
    .y_valid(v_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive at negedge, check comb, push, then pop after posedge
  task automatic step(input logic en_v, input logic [2:0] a_v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    en = en_v;
    a  = a_v;
    #1;
    checks++;
    if (yc_hi !== tbl[a_v]) begin
      errors++;
      $display("FAIL y_comb_hi a=%0d got=%h exp=%h", a_v, yc_hi, tbl[a_v]);
    end
    checks++;
    if (yc_lo !== ~tbl[a_v]) begin
      errors++;
      $display("FAIL y_comb_lo a=%0d got=%h exp=%h", a_v, yc_lo, ~tbl[a_v]);
    end
    e.v = en_v;
    e.y = en_v ? tbl[a_v] : 8'h00;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      g = sb.pop_front();
      if (y_hi !== g.y || v_hi !== g.v) begin
        errors++;
        $display("FAIL y_hi a=%0d en=%0d got=%h/%0d exp=%h/%0d",
                 a_v, en_v, y_hi, v_hi, g.y, g.v);
      end
      checks++;
      if (y_lo !== ~g.y || v_lo !== g.v) begin
        errors++;
        $display("FAIL y_lo a=%0d en=%0d got=%h/%0d exp=%h/%0d",
                 a_v, en_v, y_lo, v_lo, ~g.y, g.v);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (y_hi !== 8'h00 || v_hi !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_hi got=%h/%0d exp=00/0", y_hi, v_hi);
      end
      checks++;
      if (y_lo !== 8'hFF || v_lo !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_lo got=%h/%0d exp=ff/0", y_lo, v_lo);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b101);
    // async assert between edges while y=20
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_hi !== 8'h00 || v_hi !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_hi got=%h/%0d exp=00/0", y_hi, v_hi);
    end
    checks++;
    if (y_lo !== 8'hFF || v_lo !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_lo got=%h/%0d exp=ff/0", y_lo, v_lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b101);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i));
  endtask

  task automatic test_enable();
    step(1'b1, 3'b011);
    step(1'b0, 3'b011);
    step(1'b1, 3'b011);
  endtask

  task automatic test_polarity();
    step(1'b1, 3'b000);
    checks++;
    if (y_lo !== 8'hFE) begin
      errors++;
      $display("FAIL pol_000 got=%h exp=fe", y_lo);
    end
    step(1'b1, 3'b111);
    checks++;
    if (y_lo !== 8'h7F) begin
      errors++;
      $display("FAIL pol_111 got=%h exp=7f", y_lo);
    end
    step(1'b0, 3'b010);
    checks++;
    if (y_lo !== 8'hFF || v_lo !== 1'b0) begin
      errors++;
      $display("FAIL pol_off got=%h/%0d exp=ff/0", y_lo, v_lo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      checks++;
      if (v_hi ? ($countones(y_hi) != 1) : (y_hi !== 8'h00)) begin
        errors++;
        $display("FAIL inv_hi got=%h/%0d exp=onehot_or_00", y_hi, v_hi);
      end
      checks++;
      if (v_lo ? ($countones(~y_lo) != 1) : (y_lo !== 8'hFF)) begin
        errors++;
        $display("FAIL inv_lo got=%h/%0d exp=onecold_or_ff", y_lo, v_lo);
      end
    end
  endtask

  initial begin
    tbl    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    a      = 3'b000;
    test_reset();
    test_sweep();
    test_enable();
    test_polarity();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder3to8_b.md
Name: decoder3to8_b

Overview:
Registered 3-to-8 one-hot binary decoder with enable and an output-valid flag. It converts a 3-bit select code into an 8-bit one-hot word, with bit index equal to the code. It also exposes the same decode combinationally for same-cycle users. It is used wherever a 3-bit address or select must drive eight individual enable lines, such as a register-bank write strobe or a mux select.

Parameters:
- IN_W, 3, select width. Fixed at 3 for this block; values other than 3 are unsupported.
- OUT_W, 8, decoded width. Derived as 2**IN_W; do not override.
- ACTIVE_LOW, 0, output polarity. 0: the selected bit is 1 and the others are 0. 1: all outputs are inverted, so the selected bit is 0 and the others are 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset. Asynchronous and active-low.
- en, input, 1, decode enable, sampled on the clk rising edge.
- a, input, 3, select code. a[2] is the MSB.
- y_comb, output, 8, combinational decode of a. Not gated by en.
- y, output, 8, registered one-hot decode.
- y_valid, output, 1, high when y holds a decode of an enabled sample.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Decode function D(a): 8-bit word with bit a set and all other bits clear.
  - 000 -> 0000_0001
  - 001 -> 0000_0010
  - 010 -> 0000_0100
  - 011 -> 0000_1000
  - 100 -> 0001_0000
  - 101 -> 0010_0000
  - 110 -> 0100_0000
  - 111 -> 1000_0000
- y_comb = D(a). It is purely combinational with zero latency and follows a within the same delta. It does not depend on en or rst_n.
- Registered path, one-cycle latency, at each clk rising edge:
  - en=1: y <= D(a), y_valid <= 1.
  - en=0: y <= all-inactive (8'h00), y_valid <= 0.
- Reset:
  - rst_n low: y = all-inactive and y_valid = 0 immediately, with no clock required.
  - Reset asserted mid-operation overrides any pending capture.
  - On release, the first capture occurs at the first rising edge with rst_n high.
- Polarity: with ACTIVE_LOW=1, both y_comb and y are bitwise inverted, and "all-inactive" means 8'hFF. y_valid is always active-high.
- Invariants:
  - When y_valid=1, y is exactly one-hot (or one-cold when ACTIVE_LOW=1).
  - When y_valid=0, y is all-inactive.
- Back-to-back: a new code on every cycle with en=1 produces a new decode on every cycle. There are no bubbles and no backpressure.
- If a contains X or Z, y_comb is X. The registered y for that cycle is don't-care. There is no error flag.
- No other state, no FSM, no counters.

Decomposition:
- Shared package decoder_pkg: IN_W, OUT_W, and the function onehot3(a) returning D(a). This lets other blocks reuse the same decode.
- One natural sub-module, decoder3to8_comb. It is purely combinational, takes a and ACTIVE_LOW, and produces y_comb.
- The top module instantiates decoder3to8_comb and adds the en-gated output register and y_valid flop.

Test Plan:
- Sweep with ACTIVE_LOW=0: en=1, a = 000..111, one code per cycle.
  - y_comb tracks each code in the same cycle: 01, 02, 04, 08, 10, 20, 40, 80.
  - y shows the same sequence one cycle later, with y_valid=1 throughout.
- Reset:
  - Hold rst_n=0 for 3 cycles with en=1, a=101: y=00 and y_valid=0 throughout.
  - Assert rst_n=0 asynchronously between edges while y=20: y goes to 00 and y_valid to 0 before the next edge.
  - Release rst_n: the next edge gives y=20 and y_valid=1.
- Enable gating: a=011, en toggling 1,0,1 on successive cycles -> y = 08, 00, 08 and y_valid = 1, 0, 1. y_comb stays 08 throughout.
- Polarity with ACTIVE_LOW=1:
  - a=000 with en=1 -> y=FE.
  - a=111 with en=1 -> y=7F.
  - en=0 -> y=FF with y_valid=0.
  - Reset -> y=FF.
- Random check: 200 random cycles of a and en. Check y against the registered D(a) model each cycle, and check that popcount(y)=1 whenever y_valid=1 and y=00 whenever y_valid=0.
